// File: rtl/marin_display_pkg.sv
// -----------------------------------------------------------------------------
// marin_display_pkg
// Shared definitions for the Marin seven-segment display controller:
//   - register map (word offsets selected by wb_adr_i[3:2])
//   - CTRL register field positions
//   - 16-entry hex-to-segment table (gfedcba, active-high) and lookup helper
// -----------------------------------------------------------------------------
package marin_display_pkg;

    // Register select, taken from byte address bits [3:2].
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_CTRL   = 2'd1,
        REG_STATUS = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    // CTRL fields: one byte of digit enables, one byte of decimal points.
    localparam int CTRL_EN_LSB  = 0;
    localparam int CTRL_EN_W    = 8;
    localparam int CTRL_DP_LSB  = 8;
    localparam int CTRL_DP_W    = 8;

    // STATUS field: current digit index.
    localparam int STATUS_IDX_W = 3;

    // Hex digit to segments, bit order g f e d c b a, lit = 1.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        return HEX_SEG[value];
    endfunction

endpackage

// File: rtl/marin_hex7seg.sv
// -----------------------------------------------------------------------------
// marin_hex7seg
// Combinational hex digit to seven-segment decoder.
// Ports:
//   hex  in  4  hex value 0..F
//   seg  out 7  segments g..a, active-high (lit = 1)
// -----------------------------------------------------------------------------
module marin_hex7seg
    import marin_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/marin_display.sv
// -----------------------------------------------------------------------------
// marin_display
// Multiplexed seven-segment display controller with a Wishbone B3 classic
// slave. Scans NUM_DIGITS digits, one slot of REFRESH_DIV clocks each; the
// first BLANK_CYCLES clocks of every slot keep all anodes off to stop ghosting.
// Ports:
//   clk_i     in  1           system clock
//   rst_i     in  1           asynchronous active-high reset
//   wb_cyc_i  in  1           bus cycle
//   wb_stb_i  in  1           strobe
//   wb_we_i   in  1           write enable
//   wb_adr_i  in  4           byte address, [3:2] selects the register
//   wb_sel_i  in  4           byte enables
//   wb_dat_i  in  32          write data
//   wb_dat_o  out 32          registered read data, valid while ack is high
//   wb_ack_o  out 1           single-cycle acknowledge
//   seg       out 8           segments, [6:0] = g..a, [7] = dp
//   an        out NUM_DIGITS  digit anodes, bit 0 = rightmost digit
// -----------------------------------------------------------------------------
module marin_display
    import marin_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 65536,
    parameter int BLANK_CYCLES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRESC_W-1:0]      PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [PRESC_W-1:0]      BLANK_END  = PRESC_W'(BLANK_CYCLES);
    localparam logic [STATUS_IDX_W-1:0] IDX_LAST   = STATUS_IDX_W'(NUM_DIGITS - 1);

    // Enables come out of reset on for every physically present digit.
    localparam logic [CTRL_EN_W-1:0] EN_RESET = CTRL_EN_W'((9'd1 << NUM_DIGITS) - 9'd1);

    // Pin level meaning "off"; XOR with it turns lit=1 into board polarity.
    localparam logic [7:0]            SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                           : {NUM_DIGITS{1'b0}};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0]             data_q;
    logic [CTRL_EN_W-1:0]    en_q;
    logic [CTRL_DP_W-1:0]    dp_q;

    logic [PRESC_W-1:0]      presc_q;
    logic [STATUS_IDX_W-1:0] idx_q;

    // ------------------------------------------------------------------
    // Wishbone slave
    // ------------------------------------------------------------------
    reg_sel_e    reg_sel;
    logic        bus_req;
    logic [31:0] rd_data;

    // Byte-lane bits [1:0] only matter for sub-word masters; lanes are
    // selected by wb_sel_i instead.
    logic unused_adr;
    assign unused_adr = ^wb_adr_i[1:0];

    assign reg_sel = reg_sel_e'(wb_adr_i[3:2]);

    // Gating with ack makes a held strobe ack every other cycle.
    assign bus_req = wb_cyc_i & wb_stb_i & ~wb_ack_o;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_DATA:   rd_data = data_q;
            REG_CTRL:   rd_data = {16'h0000, dp_q, en_q};
            REG_STATUS: rd_data = {{(32 - STATUS_IDX_W){1'b0}}, idx_q};
            default:    rd_data = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together on the edge regardless of statement order.
    // NOTE: the control registers are plain flops, not a memory, so they
    // take a defined reset value and the display starts in a known state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            data_q   <= '0;
            en_q     <= EN_RESET;
            dp_q     <= '0;
        end else begin
            wb_ack_o <= bus_req;
            if (bus_req) begin
                wb_dat_o <= rd_data;
                if (wb_we_i) begin
                    case (reg_sel)
                        REG_DATA: begin
                            for (int b = 0; b < 4; b++) begin
                                if (wb_sel_i[b]) data_q[8*b +: 8] <= wb_dat_i[8*b +: 8];
                            end
                        end
                        REG_CTRL: begin
                            if (wb_sel_i[CTRL_EN_LSB / 8])
                                en_q <= wb_dat_i[CTRL_EN_LSB +: CTRL_EN_W];
                            if (wb_sel_i[CTRL_DP_LSB / 8])
                                dp_q <= wb_dat_i[CTRL_DP_LSB +: CTRL_DP_W];
                        end
                        default: ; // STATUS is read-only, offset 3 ignores writes
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Segment / anode generation
    // ------------------------------------------------------------------
    logic [3:0]            cur_hex;
    logic [6:0]            cur_seg7;
    logic                  slot_blank;
    logic [7:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    // Index is at most 7, so {idx,00} stays inside the 32-bit DATA word.
    assign cur_hex = data_q[{idx_q, 2'b00} +: 4];

    marin_hex7seg u_hex7seg (
        .hex (cur_hex),
        .seg (cur_seg7)
    );

    assign slot_blank = (presc_q < BLANK_END) || !en_q[idx_q];

    always_comb begin
        seg_next = '0;
        an_next  = '0;
        if (!slot_blank) begin
            seg_next = {dp_q[idx_q], cur_seg7};
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_next[i] = (idx_q == STATUS_IDX_W'(i));
            end
        end
    end

    // Registered pins: reset forces them off immediately, and the polarity
    // flip happens here so no combinational path reaches the board.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_next ^ SEG_OFF;
            an  <= an_next ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_marin_display.sv
// -----------------------------------------------------------------------------
// tb_marin_display
// Self-checking bench for marin_display. A 4-digit instance carries the main
// scan scenarios; a 1-digit instance shares the bus and reset. Expected lit
// slots are queued when a configuration is written and popped by a monitor
// each time a lit slot on the 4-digit display ends.
// -----------------------------------------------------------------------------
module tb_marin_display;

    localparam int ND      = 4;
    localparam int DIV     = 8;
    localparam int BLANK   = 2;
    localparam int LIT_LEN = DIV - BLANK;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic [7:0] len;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdat = '0;

    logic [31:0] dat0, dat1;
    logic        ack0, ack1;
    logic [7:0]  seg0, seg1;
    logic [3:0]  an0;
    logic [0:0]  an1;

    int checks = 0;
    int errors = 0;

    slot_t exp_q[$];

    logic [6:0] hex_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clk = ~clk;

    marin_display #(
        .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_dat_o(dat0),
        .wb_ack_o(ack0), .seg(seg0), .an(an0)
    );

    marin_display #(
        .NUM_DIGITS(1), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK), .ACTIVE_LOW(1'b1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_dat_o(dat1),
        .wb_ack_o(ack1), .seg(seg1), .an(an1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected pin pattern of one lit slot on the 4-digit display.
    function automatic slot_t model_slot(input int d, input logic [31:0] data, input logic dp);
        slot_t s;
        logic [3:0] onehot;
        onehot = 4'b0001 << d;
        s.an   = ~onehot;
        s.seg  = ~{dp, hex_tbl[data[4*d +: 4]]};
        s.len  = 8'(LIT_LEN);
        return s;
    endfunction

    // Single Wishbone transfer; returns read data of both instances.
    task automatic wb_xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r0, output logic [31:0] r1);
        int n;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack0 && n < 10);
        if (!ack0) check("wb_ack_timeout", {31'b0, ack0}, 32'd1);
        r0 = dat0;
        r1 = dat1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r0, r1;
        wb_xfer(1'b1, a, d, s, r0, r1);
    endtask

    // Wait until the digit-3 slot has ended, so the next lit slot is digit 0.
    task automatic sync_to_digit0();
        int n;
        n = 0;
        while (an0 !== 4'h7 && n < 200) begin @(negedge clk); n++; end
        while (an0 !== 4'hF && n < 200) begin @(negedge clk); n++; end
        check("sync_digit0", {31'b0, n < 200}, 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40 * DIV + 40) begin @(negedge clk); n++; end
        check(tag, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: measure each lit run on the 4-digit pins and score it.
    logic [3:0] run_an;
    logic [7:0] run_seg;
    int         run_len = 0;
    slot_t      got_item;

    always @(negedge clk) begin
        if (rst || exp_q.size() == 0) begin
            run_len = 0;
        end else if (an0 !== 4'hF) begin
            if (run_len == 0) begin
                run_an  = an0;
                run_seg = seg0;
            end else if (an0 !== run_an || seg0 !== run_seg) begin
                check("slot_tear", {20'b0, an0, seg0}, {20'b0, run_an, run_seg});
            end
            run_len++;
        end else if (run_len != 0) begin
            got_item = exp_q.pop_front();
            check("slot_an",  {28'b0, run_an}, {28'b0, got_item.an});
            check("slot_seg", {24'b0, run_seg}, {24'b0, got_item.seg});
            check("slot_len", run_len, {24'b0, got_item.len});
            run_len = 0;
        end
    end

    initial begin
        logic [31:0] r0, r1;
        logic [31:0] data_m;
        logic [7:0]  en_m, dp_m;
        int          n, lit_cnt;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_seg",  {24'b0, seg0}, 32'h0000_00FF);
        check("rst_an",   {28'b0, an0},  32'h0000_000F);
        check("rst_seg1", {24'b0, seg1}, 32'h0000_00FF);
        check("rst_an1",  {31'b0, an1},  32'h0000_0001);
        check("rst_ack",  {31'b0, ack0}, 32'd0);
        check("rst_dat",  dat0, 32'd0);
        rst = 1'b0;

        // Reset asserted while a digit is lit drops the pins without a clock.
        n = 0;
        while (an0 === 4'hF && n < 100) begin @(negedge clk); n++; end
        check("lit_before_reset", {31'b0, an0 !== 4'hF}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_seg", {24'b0, seg0}, 32'h0000_00FF);
        check("async_rst_an",  {28'b0, an0},  32'h0000_000F);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        wb_xfer(1'b0, 4'h0, 32'h0, 4'hF, r0, r1);
        check("rd_data_rst", r0, 32'h0000_0000);
        wb_xfer(1'b0, 4'h4, 32'h0, 4'hF, r0, r1);
        check("rd_ctrl_rst", r0, 32'h0000_000F);
        check("rd_ctrl_rst_1dig", r1, 32'h0000_0001);

        // ---------------- DATA = BEEF, all digits enabled ----------------
        data_m = 32'h0000_BEEF; en_m = 8'h0F; dp_m = 8'h00;
        wb_write(4'h0, data_m, 4'hF);
        sync_to_digit0();
        for (int k = 0; k < 8; k++) exp_q.push_back(model_slot(k % ND, data_m, dp_m[k % ND]));
        drain("beef_scan_done");

        // ---------------- CTRL = 0x20D: digit 1 off, its dp hidden ----------------
        en_m = 8'h0D; dp_m = 8'h02;
        wb_write(4'h4, 32'h0000_020D, 4'hF);
        wb_xfer(1'b0, 4'h4, 32'h0, 4'hF, r0, r1);
        check("rd_ctrl_20d", r0, 32'h0000_020D);
        sync_to_digit0();
        for (int k = 0; k < 8; k++)
            if (en_m[k % ND]) exp_q.push_back(model_slot(k % ND, data_m, dp_m[k % ND]));
        drain("ctrl20d_scan_done");

        // ---------------- CTRL = 0x40F: dp on digit 2 ----------------
        en_m = 8'h0F; dp_m = 8'h04;
        wb_write(4'h4, 32'h0000_040F, 4'hF);
        sync_to_digit0();
        for (int k = 0; k < 8; k++) exp_q.push_back(model_slot(k % ND, data_m, dp_m[k % ND]));
        drain("ctrl40f_scan_done");

        // ---------------- single-digit instance ----------------
        lit_cnt = 0;
        for (int k = 0; k < 2 * DIV; k++) begin
            @(negedge clk);
            if (an1 === 1'b0) lit_cnt++;
        end
        check("one_digit_lit_cycles", lit_cnt, 32'(2 * LIT_LEN));
        for (int k = 0; k < 3; k++) begin
            wb_xfer(1'b0, 4'h8, 32'h0, 4'hF, r0, r1);
            check("one_digit_status", r1, 32'd0);
            repeat (3) @(posedge clk);
        end

        // ---------------- byte-granular writes ----------------
        wb_write(4'h0, 32'h1234_5678, 4'hF);
        wb_write(4'h0, 32'hFFFF_FFAB, 4'b0001);
        wb_xfer(1'b0, 4'h0, 32'h0, 4'hF, r0, r1);
        check("byte_wr_lane0", r0, 32'h1234_56AB);
        wb_write(4'h0, 32'hAABB_CCDD, 4'b1010);
        wb_xfer(1'b0, 4'h0, 32'h0, 4'hF, r0, r1);
        check("byte_wr_lanes31", r0, 32'hAA34_CCAB);

        // Offset 3: writes ignored, reads zero; STATUS not writable.
        wb_write(4'hC, 32'hFFFF_FFFF, 4'hF);
        wb_xfer(1'b0, 4'hC, 32'h0, 4'hF, r0, r1);
        check("rd_reserved", r0, 32'd0);
        wb_write(4'h8, 32'hFFFF_FFFF, 4'hF);
        wb_xfer(1'b0, 4'h8, 32'h0, 4'hF, r0, r1);
        check("status_range", {31'b0, r0 < ND}, 32'd1);
        wb_xfer(1'b0, 4'h4, 32'h0, 4'hF, r0, r1);
        check("ctrl_after_misc", r0, 32'h0000_040F);

        // ---------------- held strobe: ack every other cycle ----------------
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'hC; sel = 4'hF;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) begin @(posedge clk); #1; end
            check("held_ack", {31'b0, ack0}, 32'(k % 2));
            if (ack0) check("held_rd_reserved", dat0, 32'd0);
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        check("watchdog", 32'd1, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
